regfile_wb_ctrl: RTL

Write-port controller for the 2-read/1-write register file. It owns the single `rd_*` write port and shares it between `NREQ` writeback requesters with round-robin arbitration and a valid/ready handshake. After reset it can optionally run an initialisation sweep that writes zero to every architectural register, so the register file never exposes uninitialised data. It sits between the execution/load writeback stages and the register file write port.

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_wb_ctrl_if.sv | 19 +
 rtl/regfile_wb_ctrl_rr_arbiter.sv | 35 +++
 rtl/regfile_wb_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the register file and its write-port controller
package regfile_pkg;
  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} wb_state_t;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH_LOG2 = 4;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: requester handshake bus plus register-file write port
interface regfile_wb_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int NREQ       = 2
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ*DEPTH_LOG2-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]      req_data;
  logic                       rd_write;
  logic [DEPTH_LOG2-1:0]      rd_addr;
  logic [WIDTH-1:0]           rd_wdata;
  logic                       init_busy;
  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, rd_write, rd_addr, rd_wdata, init_busy);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, rd_write, rd_addr, rd_wdata, init_busy);
endinterface

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant with a registered priority pointer
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_any;
  int            j;
  // Scan offsets high to low so the nearest requester after the pointer wins
  always_comb begin
    w_idx = r_ptr;
    w_any = 1'b0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (i_req[j]) begin
        w_idx = PW'(j);
        w_any = 1'b1;
      end
    end
    o_gnt = w_any ? (NREQ'(1) << w_idx) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_ptr <= '0;
    else if (i_advance)
      r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: shares the register-file write port among NREQ requesters (round robin).
// Defining REGFILE_WB_CTRL_INIT_EN adds a post-reset sweep that zeroes registers 1..2^DEPTH_LOG2-1.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int NREQ       = 2
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_ctrl_if.slave  bus
);
  logic                  w_init;
  logic [DEPTH_LOG2-1:0] w_sweep_addr;
  logic [NREQ-1:0]       w_gnt;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [WIDTH-1:0]      w_data;
  logic                  r_write;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
`ifdef REGFILE_WB_CTRL_INIT_EN
  wb_state_t             r_state;
  logic [DEPTH_LOG2-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= DEPTH_LOG2'(1);
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) r_state <= RUN;
    end
  assign w_init       = (r_state == INIT);
  assign w_sweep_addr = r_cnt;
`else
  assign w_init       = 1'b0;
  assign w_sweep_addr = '0;
`endif
  // Masking requests keeps ready low during the sweep and while reset is held
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req_valid & {NREQ{~w_init & ~rst}}),
    .i_advance (|w_gnt),
    .o_gnt     (w_gnt)
  );
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (w_gnt[k]) begin
        w_addr = bus.req_addr[k*DEPTH_LOG2 +: DEPTH_LOG2];
        w_data = bus.req_data[k*WIDTH +: WIDTH];
      end
  end
  // Address 0 is hardwired in the register file, so its writes are accepted but not strobed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_init) begin
      r_write <= 1'b1;
      r_addr  <= w_sweep_addr;
      r_wdata <= '0;
    end else if (|w_gnt) begin
      r_write <= |w_addr;
      r_addr  <= w_addr;
      r_wdata <= w_data;
    end else
      r_write <= 1'b0;
  assign bus.req_ready = w_gnt;
  assign bus.rd_write  = r_write;
  assign bus.rd_addr   = r_addr;
  assign bus.rd_wdata  = r_wdata;
  assign bus.init_busy = w_init;
endmodule
